// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit-side arbitration logic:
// arbiter state encoding, default byte width and a width helper.
package uart_pkg;

  localparam int NB_DATA_DEFAULT = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_LOAD = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_t;

  // Bits needed to hold 0..value-1; never less than 1.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// scanning upward from the slot after last_ptr, wrapping at N_REQ.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int PTR_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] last_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  logic [PTR_W-1:0] idx;

  // Rotating priority scan; the first set bit after last_ptr wins.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = PTR_W'((int'(last_ptr) + off) % N_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters using
// round-robin arbitration. IDLE grants and latches the byte, LOAD issues
// the start/ack pulses, BUSY holds ownership until the transmitter reports
// completion. Optional BUSY watchdog: define TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NB_DATA        = NB_DATA_DEFAULT,
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*NB_DATA-1:0] i_data,
  output logic [N_REQ-1:0]         o_ack,
  output logic [N_REQ-1:0]         o_done,
  output logic                     o_busy,
  output logic                     o_tx_start,
  output logic [NB_DATA-1:0]       o_tx_data,
  input  logic                     i_tx_done,
  output logic                     o_timeout
);

  localparam int PTR_W = clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end

  arb_state_t         state, state_nxt;
  logic [N_REQ-1:0]   grant, grant_nxt;
  logic [PTR_W-1:0]   grant_idx, grant_idx_nxt;
  logic [PTR_W-1:0]   last_ptr, last_ptr_nxt;
  logic [NB_DATA-1:0] tx_data_nxt;
  logic [N_REQ-1:0]   ack_nxt, done_nxt;
  logic               busy_nxt, start_nxt, timeout_nxt;

  logic [N_REQ-1:0]   arb_gnt;
  logic [PTR_W-1:0]   arb_idx;
  logic               arb_any;

`ifdef TX_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req      (i_req),
    .last_ptr (last_ptr),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .any      (arb_any)
  );

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    grant_idx_nxt = grant_idx;
    last_ptr_nxt  = last_ptr;
    tx_data_nxt   = o_tx_data;
    busy_nxt      = o_busy;
    start_nxt     = 1'b0;
    ack_nxt       = '0;
    done_nxt      = '0;
    timeout_nxt   = 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
    cnt_nxt       = cnt;
`endif
    case (state)
      ARB_IDLE: begin
        if (arb_any) begin
          grant_nxt     = arb_gnt;
          grant_idx_nxt = arb_idx;
          busy_nxt      = 1'b1;
          state_nxt     = ARB_LOAD;
          for (int k = 0; k < N_REQ; k++) begin
            if (arb_gnt[k]) tx_data_nxt = i_data[k*NB_DATA +: NB_DATA];
          end
        end
      end
      ARB_LOAD: begin
        start_nxt    = 1'b1;
        ack_nxt      = grant;
        last_ptr_nxt = grant_idx;
        state_nxt    = ARB_BUSY;
`ifdef TX_ARB_TIMEOUT_EN
        cnt_nxt      = '0;
`endif
      end
      ARB_BUSY: begin
        if (i_tx_done) begin
          done_nxt  = grant;
          busy_nxt  = 1'b0;
          state_nxt = ARB_IDLE;
        end
`ifdef TX_ARB_TIMEOUT_EN
        else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = ARB_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State, grant bookkeeping and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_ptr   <= PTR_W'(N_REQ - 1);
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_tx_start <= 1'b0;
      o_ack      <= '0;
      o_done     <= '0;
      o_timeout  <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      grant_idx  <= grant_idx_nxt;
      last_ptr   <= last_ptr_nxt;
      o_tx_data  <= tx_data_nxt;
      o_busy     <= busy_nxt;
      o_tx_start <= start_nxt;
      o_ack      <= ack_nxt;
      o_done     <= done_nxt;
      o_timeout  <= timeout_nxt;
`ifdef TX_ARB_TIMEOUT_EN
      cnt        <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, NB_DATA=8,
// TIMEOUT_CYCLES=50). Inputs change 1 ns after the rising edge and
// outputs are sampled at that same point.
module tb_uart_tx_arbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_req;
  logic [31:0] i_data;
  logic [3:0]  o_ack;
  logic [3:0]  o_done;
  logic        o_busy;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        i_tx_done;
  logic        o_timeout;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NB_DATA(8), .N_REQ(4), .TIMEOUT_CYCLES(50)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_req      (i_req),
    .i_data     (i_data),
    .o_ack      (o_ack),
    .o_done     (o_done),
    .o_busy     (o_busy),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .i_tx_done  (i_tx_done),
    .o_timeout  (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Bounded wait for the start pulse.
  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (o_tx_start !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check({tag, " start"}, 32'(o_tx_start), 32'd1);
  endtask

  // Full transaction from start pulse to done pulse for requester idx.
  task automatic serve(input string tag, input int idx, input logic [7:0] byt);
    wait_start(tag);
    check({tag, " ack"}, 32'(o_ack), 32'(1 << idx));
    check({tag, " data"}, 32'(o_tx_data), 32'(byt));
    step();
    check({tag, " start fall"}, 32'(o_tx_start), 32'd0);
    check({tag, " data held"}, 32'(o_tx_data), 32'(byt));
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check({tag, " done"}, 32'(o_done), 32'(1 << idx));
    check({tag, " busy fall"}, 32'(o_busy), 32'd0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
  endtask

  initial begin
    i_reset   = 1'b1;
    i_req     = '0;
    i_data    = '0;
    i_tx_done = 1'b0;

    // Reset values
    do_reset();
    check("rst ack", 32'(o_ack), 32'd0);
    check("rst done", 32'(o_done), 32'd0);
    check("rst busy", 32'(o_busy), 32'd0);
    check("rst start", 32'(o_tx_start), 32'd0);
    check("rst data", 32'(o_tx_data), 32'd0);
    check("rst timeout", 32'(o_timeout), 32'd0);

    // 1. Single request, exact latency
    i_req  = 4'b0100;
    i_data = 32'h00A5_0000;
    step();
    check("t1 busy at grant", 32'(o_busy), 32'd1);
    check("t1 no start k+1", 32'(o_tx_start), 32'd0);
    step();
    check("t1 start k+2", 32'(o_tx_start), 32'd1);
    check("t1 ack k+2", 32'(o_ack), 32'b0100);
    check("t1 data", 32'(o_tx_data), 32'hA5);
    i_req = '0;
    step();
    check("t1 ack fall", 32'(o_ack), 32'd0);
    step();
    check("t1 data held", 32'(o_tx_data), 32'hA5);
    check("t1 no early done", 32'(o_done), 32'd0);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("t1 done", 32'(o_done), 32'b0100);
    check("t1 busy fall", 32'(o_busy), 32'd0);
    step();
    check("t1 done pulse", 32'(o_done), 32'd0);

    // 2. Contention after reset: 0,1,2,3,0 with 2-cycle done->start gap
    do_reset();
    i_data = 32'h1312_1110;
    i_req  = 4'b1111;
    serve("t2 g0", 0, 8'h10);
    step(); check("t2 gap a", 32'(o_tx_start), 32'd0);
    step(); check("t2 gap b", 32'(o_tx_start), 32'd1);
    serve("t2 g1", 1, 8'h11);
    step(); check("t2 gap c", 32'(o_tx_start), 32'd0);
    step(); check("t2 gap d", 32'(o_tx_start), 32'd1);
    serve("t2 g2", 2, 8'h12);
    step(); check("t2 gap e", 32'(o_tx_start), 32'd0);
    step(); check("t2 gap f", 32'(o_tx_start), 32'd1);
    serve("t2 g3", 3, 8'h13);
    step(); check("t2 gap g", 32'(o_tx_start), 32'd0);
    step(); check("t2 gap h", 32'(o_tx_start), 32'd1);
    i_req = '0;
    serve("t2 g0b", 0, 8'h10);

    // 3. Lone requester back-to-back, then wrap and skip with 1010
    i_req = 4'b1000;
    serve("t3 lone a", 3, 8'h13);
    serve("t3 lone b", 3, 8'h13);
    i_req = 4'b1010;
    serve("t3 wrap 1", 1, 8'h11);
    serve("t3 skip 3", 3, 8'h13);
    serve("t3 again 1", 1, 8'h11);
    i_req = '0;
    step();
    check("t3 idle busy", 32'(o_busy), 32'd0);

    // 4. Spurious done in IDLE; done coinciding with a new request
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("t4 spurious done", 32'(o_done), 32'd0);
    check("t4 spurious busy", 32'(o_busy), 32'd0);
    step();
    check("t4 spurious done b", 32'(o_done), 32'd0);
    i_req = 4'b0001;
    wait_start("t4 first");
    check("t4 first ack", 32'(o_ack), 32'b0001);
    i_req = '0;
    step();
    i_tx_done = 1'b1;
    i_req     = 4'b0100;
    step();
    i_tx_done = 1'b0;
    check("t4 coincide done", 32'(o_done), 32'b0001);
    check("t4 coincide busy", 32'(o_busy), 32'd0);
    check("t4 coincide no ack", 32'(o_ack), 32'd0);
    step();
    check("t4 grant in idle", 32'(o_busy), 32'd1);
    check("t4 no start yet", 32'(o_tx_start), 32'd0);
    step();
    check("t4 late start", 32'(o_tx_start), 32'd1);
    check("t4 late ack", 32'(o_ack), 32'b0100);
    check("t4 late data", 32'(o_tx_data), 32'h12);
    i_req = '0;
    step();
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("t4 late done", 32'(o_done), 32'b0100);

    // 5. Reset mid-BUSY abandons the grant
    step();
    i_req = 4'b0100;
    wait_start("t5 pre");
    check("t5 pre ack", 32'(o_ack), 32'b0100);
    i_req = '0;
    step();
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("t5 ack", 32'(o_ack), 32'd0);
    check("t5 done", 32'(o_done), 32'd0);
    check("t5 busy", 32'(o_busy), 32'd0);
    check("t5 start", 32'(o_tx_start), 32'd0);
    check("t5 data", 32'(o_tx_data), 32'd0);
    check("t5 timeout", 32'(o_timeout), 32'd0);
    step();
    check("t5 no done after", 32'(o_done), 32'd0);
    i_req = 4'b1111;
    serve("t5 post", 0, 8'h10);
    i_req = '0;

    // 6. Watchdog (or its absence in the default build)
    step();
    i_req = 4'b0010;
    wait_start("t6 grant");
    check("t6 ack", 32'(o_ack), 32'b0010);
    i_req = '0;
`ifdef TX_ARB_TIMEOUT_EN
    for (int i = 1; i < 50; i++) begin
      step();
      check("t6 no early timeout", 32'(o_timeout), 32'd0);
    end
    check("t6 busy before limit", 32'(o_busy), 32'd1);
    step();
    check("t6 timeout", 32'(o_timeout), 32'd1);
    check("t6 timeout busy", 32'(o_busy), 32'd0);
    check("t6 timeout no done", 32'(o_done), 32'd0);
    step();
    check("t6 timeout pulse", 32'(o_timeout), 32'd0);
`else
    for (int i = 0; i < 60; i++) begin
      step();
      check("t6 timeout tied", 32'(o_timeout), 32'd0);
    end
    check("t6 still busy", 32'(o_busy), 32'd1);
    i_tx_done = 1'b1;
    step();
    i_tx_done = 1'b0;
    check("t6 late done", 32'(o_done), 32'b0010);
`endif
    i_req = 4'b0011;
    serve("t6 next", 0, 8'h10);
    i_req = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
